traceback_unit: RTL and testbench
=================================

# traceback_unit

Consumer-side companion to the systolic edit-distance PE array. It captures the 3-bit per-cell direction pointers that the B processing elements emit each cycle into an L×L pointer store. On command, it walks the stored pointers from a chosen end cell back to the origin and streams the alignment as a sequence of edit operations over a valid/ready handshake.

## Interface
- B, 4, number of PE lanes written per cycle
- L, 16, sequence length; the store holds cells (i,j) with i,j in 1..L
- IW, $clog2(L+1), width of row and column indices
- clk  in  1  clock; all logic is rising-edge
- reset  in  1  synchronous, active-high; clears all state including the pointer store
- wr_valid  in  B  per-lane pointer write enable
- wr_row  in  B*IW  lane k at [k*IW +: IW]; row index i (reference base)
- wr_col  in  B*IW  lane k at [k*IW +: IW]; column index j (query base)
- wr_ptr  in  B*3  lane k at [k*3 +: 3]; pointer code
- clear  in  1  one-cycle pulse; zeroes the store (IDLE only)
- start  in  1  one-cycle pulse; begin traceback (IDLE only)
- start_row, start_col  in  IW each  end cell of the traceback
- op_valid  out  1  op_code is valid
- op_ready  in  1  downstream accepts the op
- op_code  out  2  00 match, 01 mismatch, 10 deletion (i-1), 11 insertion (j-1)
- op_last  out  1  final op of the path
- busy  out  1  state is TRACE
- done  out  1  one-cycle pulse at the end of every traceback
- err  out  1  sticky; set on a bad pointer, cleared by the next accepted start
- op_count  out  IW+1  number of ops accepted in the current or last traceback

## Operation
- Pointer codes: 001 diag-match, 010 diag-mismatch, 011 up, 100 left. 000 means unwritten. 101, 110 and 111 are illegal.
- Writes:
  - Accepted only in IDLE.
  - Lanes with row or col equal to 0 or greater than L are ignored.
  - When lanes collide on the same cell, the highest lane index wins.
  - Writes in TRACE are dropped.
- clear: takes one cycle and zeroes all cells. When clear and writes occur in the same cycle, clear wins.
- States are IDLE, TRACE.
- IDLE → TRACE on start. This latches cur=(start_row,start_col), zeroes op_count and clears err. Same-cycle writes commit before the first read. When start and clear coincide, start is ignored.
- In TRACE, the op at cur=(i,j) is determined as follows:
  - i>0, j>0: read ptr(i,j).
    - 001: match, next (i-1,j-1).
    - 010: mismatch, next (i-1,j-1).
    - 011: deletion, next (i-1,j).
    - 100: insertion, next (i,j-1).
  - i>0, j=0: deletion, next (i-1,0).
  - i=0, j>0: insertion, next (0,j-1).
  - op_last=1 when the next coordinate is (0,0).
- On handshake (op_valid & op_ready): cur ← next and op_count increments. If op_last, return to IDLE and pulse done.
- Bad pointer (000 or 101–111) at an interior cell:
  - No op is presented for that cell.
  - err is set, done pulses, and the state returns to IDLE.
- Start at (0,0): no ops are emitted, done pulses, and the state returns to IDLE.
- Maximum path length is 2L ops. op_count never wraps.
- Reset values: op_valid=0, op_code=00, op_last=0, busy=0, done=0, err=0, op_count=0, store all 000, state IDLE.

## Timing
- start accepted at cycle t → busy=1 and op_valid=1 with the first op at t+1. For the (0,0) or bad-pointer cases, done=1 at t+1 and op_valid stays 0.
- Output registers hold op_code and op_last stable while op_valid=1 and op_ready=0.
- Throughput is one op per cycle under continuous op_ready: an op accepted at cycle c yields the next op at c+1.
- Last op accepted at cycle c → done=1 and busy=0 at c+1. A new start is accepted at c+1.
- A bad pointer reached after the op accepted at cycle c → err=1 and done=1 at c+1.
- Reset during TRACE: at the next edge, all outputs and the store take their reset values. No further ops are emitted.

## Test plan
- Diagonal path (L=4): write 001 to (1,1)…(4,4) over two cycles of 2 lanes each, start (4,4) → ops 00,00,00,00 on cycles t+1..t+4; op_last on the 4th op; done at t+5; op_count=4.
- Mixed path: (3,3)=010, (2,2)=011, (1,2)=100, (1,1)=001, start (3,3) → ops 01,10,11,00, then op_last; op_count=4.
- Boundary walk: start (0,3) → ops 11,11,11, op_last on the 3rd. Start (0,0) → done at t+1 with no op_valid.
- Backpressure: on the diagonal path, drop op_ready for 3 cycles after the 2nd op → op_code held at 00 and op_valid held at 1, with no op lost or duplicated; 4 ops total.
- Bad pointer: clear, write only (2,2)=001, start (2,2) → op 00, then err=1 and done=1 with no second op; err cleared by the next start.
- Collision and reset: lanes 0 and 2 write (1,1) with 011 and 100 → the trace yields op 11. Reset asserted mid-trace → op_valid=0 next cycle, and a subsequent start on (1,1) sets err (store cleared).

Source files
------------

// File: rtl/traceback_if.sv
// Bundle for the traceback unit: pointer write lanes, the trace command, and the op stream with its handshake.
interface traceback_if #(
  parameter int unsigned B = 4,
  parameter int unsigned L = 16
);
  localparam int unsigned IW = $clog2(L + 1);

  logic [B-1:0]    wr_valid;
  logic [B*IW-1:0] wr_row;
  logic [B*IW-1:0] wr_col;
  logic [B*3-1:0]  wr_ptr;
  logic            clear;
  logic            start;
  logic [IW-1:0]   start_row;
  logic [IW-1:0]   start_col;
  logic            op_valid;
  logic            op_ready;
  logic [1:0]      op_code;
  logic            op_last;
  logic            busy;
  logic            done;
  logic            err;
  logic [IW:0]     op_count;

  // Producer / consumer side driving the unit
  modport master (
    output wr_valid, wr_row, wr_col, wr_ptr, clear, start, start_row, start_col, op_ready,
    input  op_valid, op_code, op_last, busy, done, err, op_count
  );

  // The traceback unit itself
  modport slave (
    input  wr_valid, wr_row, wr_col, wr_ptr, clear, start, start_row, start_col, op_ready,
    output op_valid, op_code, op_last, busy, done, err, op_count
  );
endinterface

// File: rtl/traceback_unit.sv
// Traceback unit: stores per-cell direction pointers from the PE array and
// walks them from an end cell back to (0,0), streaming one edit op per cycle.
module traceback_unit #(
  parameter int unsigned B = 4,
  parameter int unsigned L = 16
) (
  input  logic       clk,
  input  logic       reset,
  traceback_if.slave bus
);
  localparam int unsigned IW = $clog2(L + 1);
  localparam int unsigned CW = IW + 1;
  localparam int unsigned NC = L * L;
  localparam int unsigned AW = (NC > 1) ? $clog2(NC) : 1;

  localparam logic [2:0] PTR_MATCH = 3'b001;
  localparam logic [2:0] PTR_MISM  = 3'b010;
  localparam logic [2:0] PTR_UP    = 3'b011;
  localparam logic [2:0] PTR_LEFT  = 3'b100;

  localparam logic [1:0] OP_MATCH = 2'b00;
  localparam logic [1:0] OP_MISM  = 2'b01;
  localparam logic [1:0] OP_DEL   = 2'b10;
  localparam logic [1:0] OP_INS   = 2'b11;

  typedef enum logic {S_IDLE, S_TRACE} state_t;

  state_t        state;
  logic [2:0]    store [NC];
  logic [IW-1:0] nxt_i;
  logic [IW-1:0] nxt_j;

  logic [IW-1:0] rd_i;
  logic [IW-1:0] rd_j;
  logic [2:0]    rd_ptr;
  logic          ev_bad;
  logic          ev_term;
  logic [1:0]    ev_code;
  logic [IW-1:0] nx_i;
  logic [IW-1:0] nx_j;
  logic          ev_last;

  function automatic logic in_range(input logic [IW-1:0] i, input logic [IW-1:0] j);
    return (i != '0) && (j != '0) && (32'(i) <= L) && (32'(j) <= L);
  endfunction

  function automatic logic [AW-1:0] cell_idx(input logic [IW-1:0] i, input logic [IW-1:0] j);
    int unsigned lin;
    lin = 0;
    if (in_range(i, j)) lin = (32'(i) - 32'd1) * L + (32'(j) - 32'd1);
    return AW'(lin);
  endfunction

  // Pointer read for the cell to evaluate; in IDLE, same-cycle lane writes are forwarded
  always_comb begin
    rd_i   = (state == S_IDLE) ? bus.start_row : nxt_i;
    rd_j   = (state == S_IDLE) ? bus.start_col : nxt_j;
    rd_ptr = store[cell_idx(rd_i, rd_j)];
    if (state == S_IDLE) begin
      for (int k = 0; k < int'(B); k++) begin
        if (bus.wr_valid[k] && in_range(bus.wr_row[k*IW +: IW], bus.wr_col[k*IW +: IW]) &&
            bus.wr_row[k*IW +: IW] == rd_i && bus.wr_col[k*IW +: IW] == rd_j)
          rd_ptr = bus.wr_ptr[k*3 +: 3];
      end
    end
  end

  // Decode the op, successor cell and path status for the cell being evaluated
  always_comb begin
    ev_bad  = 1'b0;
    ev_term = 1'b0;
    ev_code = OP_MATCH;
    nx_i    = rd_i;
    nx_j    = rd_j;
    if (32'(rd_i) > L || 32'(rd_j) > L) begin
      ev_bad = 1'b1;
    end else if (rd_i == '0 && rd_j == '0) begin
      ev_term = 1'b1;
    end else if (rd_j == '0) begin
      ev_code = OP_DEL;
      nx_i    = rd_i - IW'(1);
    end else if (rd_i == '0) begin
      ev_code = OP_INS;
      nx_j    = rd_j - IW'(1);
    end else begin
      case (rd_ptr)
        PTR_MATCH: begin ev_code = OP_MATCH; nx_i = rd_i - IW'(1); nx_j = rd_j - IW'(1); end
        PTR_MISM:  begin ev_code = OP_MISM;  nx_i = rd_i - IW'(1); nx_j = rd_j - IW'(1); end
        PTR_UP:    begin ev_code = OP_DEL;   nx_i = rd_i - IW'(1); end
        PTR_LEFT:  begin ev_code = OP_INS;   nx_j = rd_j - IW'(1); end
        default:   ev_bad = 1'b1;
      endcase
    end
    ev_last = (nx_i == '0) && (nx_j == '0);
  end

  // Control FSM, pointer store and registered op stream
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      nxt_i        <= '0;
      nxt_j        <= '0;
      bus.op_valid <= 1'b0;
      bus.op_code  <= OP_MATCH;
      bus.op_last  <= 1'b0;
      bus.busy     <= 1'b0;
      bus.done     <= 1'b0;
      bus.err      <= 1'b0;
      bus.op_count <= '0;
      for (int n = 0; n < int'(NC); n++) store[n] <= 3'b000;
    end else begin
      bus.done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.clear) begin
            for (int n = 0; n < int'(NC); n++) store[n] <= 3'b000;
          end else begin
            for (int k = 0; k < int'(B); k++) begin
              if (bus.wr_valid[k] && in_range(bus.wr_row[k*IW +: IW], bus.wr_col[k*IW +: IW]))
                store[cell_idx(bus.wr_row[k*IW +: IW], bus.wr_col[k*IW +: IW])] <= bus.wr_ptr[k*3 +: 3];
            end
            if (bus.start) begin
              bus.op_count <= '0;
              if (ev_bad || ev_term) begin
                bus.done <= 1'b1;
                bus.err  <= ev_bad;
              end else begin
                state        <= S_TRACE;
                bus.busy     <= 1'b1;
                bus.err      <= 1'b0;
                bus.op_valid <= 1'b1;
                bus.op_code  <= ev_code;
                bus.op_last  <= ev_last;
                nxt_i        <= nx_i;
                nxt_j        <= nx_j;
              end
            end
          end
        end
        S_TRACE: begin
          if (bus.op_valid && bus.op_ready) begin
            bus.op_count <= bus.op_count + CW'(1);
            if (bus.op_last || ev_bad) begin
              state        <= S_IDLE;
              bus.busy     <= 1'b0;
              bus.op_valid <= 1'b0;
              bus.op_last  <= 1'b0;
              bus.done     <= 1'b1;
              if (!bus.op_last) bus.err <= 1'b1;
            end else begin
              bus.op_code <= ev_code;
              bus.op_last <= ev_last;
              nxt_i       <= nx_i;
              nxt_j       <= nx_j;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_traceback_unit.sv
// Directed bench for traceback_unit with hand-computed op sequences (L=4, B=4).
module tb_traceback_unit;
  localparam int unsigned B  = 4;
  localparam int unsigned L  = 4;
  localparam int unsigned IW = $clog2(L + 1);

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;

  traceback_if #(.B(B), .L(L)) bus ();
  traceback_unit #(.B(B), .L(L)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_lanes();
    bus.wr_valid = '0;
    bus.wr_row   = '0;
    bus.wr_col   = '0;
    bus.wr_ptr   = '0;
  endtask

  task automatic set_lane(input int k, input int r, input int c, input logic [2:0] p);
    bus.wr_valid[k]         = 1'b1;
    bus.wr_row[k*IW +: IW]  = IW'(r);
    bus.wr_col[k*IW +: IW]  = IW'(c);
    bus.wr_ptr[k*3 +: 3]    = p;
  endtask

  task automatic do_clear();
    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
  endtask

  task automatic kick(input int r, input int c);
    bus.start     = 1'b1;
    bus.start_row = IW'(r);
    bus.start_col = IW'(c);
    tick();
    bus.start = 1'b0;
  endtask

  task automatic write_diag();
    set_lane(0, 1, 1, 3'b001); set_lane(1, 2, 2, 3'b001); tick(); clear_lanes();
    set_lane(0, 3, 3, 3'b001); set_lane(1, 4, 4, 3'b001); tick(); clear_lanes();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    n_checks++;
    if ({bus.busy, bus.op_valid, bus.op_code, bus.op_last, bus.done, bus.err} !== 7'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b expected 0000000",
               {bus.busy, bus.op_valid, bus.op_code, bus.op_last, bus.done, bus.err});
    end
    n_checks++;
    if (bus.op_count !== '0) begin
      n_fail++; $display("FAIL reset_count: got %0d expected 0", bus.op_count);
    end
  endtask

  task automatic test_diagonal();
    do_clear();
    write_diag();
    bus.op_ready = 1'b1;
    kick(4, 4);
    for (int n = 0; n < 4; n++) begin
      n_checks++;
      if ({bus.busy, bus.op_valid, bus.op_code, bus.op_last} !== {1'b1, 1'b1, 2'b00, n == 3}) begin
        n_fail++;
        $display("FAIL diag_op%0d: got busy/valid/code/last %b expected %b", n,
                 {bus.busy, bus.op_valid, bus.op_code, bus.op_last}, {1'b1, 1'b1, 2'b00, n == 3});
      end
      tick();
    end
    n_checks++;
    if ({bus.done, bus.busy, bus.op_valid} !== 3'b100) begin
      n_fail++; $display("FAIL diag_done: got done/busy/valid %b expected 100", {bus.done, bus.busy, bus.op_valid});
    end
    n_checks++;
    if (bus.op_count !== 4'd4) begin
      n_fail++; $display("FAIL diag_count: got %0d expected 4", bus.op_count);
    end
    tick();
    n_checks++;
    if (bus.done !== 1'b0) begin
      n_fail++; $display("FAIL diag_done_pulse: got %b expected 0", bus.done);
    end
  endtask

  task automatic test_mixed();
    logic [1:0] exp_codes [4];
    exp_codes = '{2'b01, 2'b10, 2'b11, 2'b00};
    do_clear();
    // Writes land in the same cycle as start to exercise commit-before-read
    set_lane(0, 3, 3, 3'b010); set_lane(1, 2, 2, 3'b011);
    set_lane(2, 1, 2, 3'b100); set_lane(3, 1, 1, 3'b001);
    bus.op_ready = 1'b1;
    kick(3, 3);
    clear_lanes();
    for (int n = 0; n < 4; n++) begin
      n_checks++;
      if ({bus.op_valid, bus.op_code, bus.op_last} !== {1'b1, exp_codes[n], n == 3}) begin
        n_fail++;
        $display("FAIL mixed_op%0d: got valid/code/last %b expected %b", n,
                 {bus.op_valid, bus.op_code, bus.op_last}, {1'b1, exp_codes[n], n == 3});
      end
      tick();
    end
    n_checks++;
    if ({bus.done, bus.op_count} !== {1'b1, 4'd4}) begin
      n_fail++; $display("FAIL mixed_end: got done=%b count=%0d expected done=1 count=4", bus.done, bus.op_count);
    end
  endtask

  task automatic test_boundary();
    bus.op_ready = 1'b1;
    kick(0, 3);
    for (int n = 0; n < 3; n++) begin
      n_checks++;
      if ({bus.op_valid, bus.op_code, bus.op_last} !== {1'b1, 2'b11, n == 2}) begin
        n_fail++;
        $display("FAIL edge_op%0d: got valid/code/last %b expected %b", n,
                 {bus.op_valid, bus.op_code, bus.op_last}, {1'b1, 2'b11, n == 2});
      end
      tick();
    end
    n_checks++;
    if ({bus.done, bus.op_count} !== {1'b1, 4'd3}) begin
      n_fail++; $display("FAIL edge_end: got done=%b count=%0d expected done=1 count=3", bus.done, bus.op_count);
    end
    kick(0, 0);
    n_checks++;
    if ({bus.done, bus.busy, bus.op_valid, bus.err, bus.op_count} !== {4'b1000, 4'd0}) begin
      n_fail++;
      $display("FAIL origin_start: got done/busy/valid/err=%b count=%0d expected 1000 count=0",
               {bus.done, bus.busy, bus.op_valid, bus.err}, bus.op_count);
    end
  endtask

  task automatic test_backpressure();
    do_clear();
    write_diag();
    bus.op_ready = 1'b1;
    kick(4, 4);
    tick();
    bus.op_ready = 1'b0;
    // A write during the trace must not disturb the last cell
    set_lane(0, 1, 1, 3'b100);
    for (int s = 0; s < 3; s++) begin
      tick();
      n_checks++;
      if ({bus.op_valid, bus.op_code, bus.op_last, bus.op_count} !== {1'b1, 2'b00, 1'b0, 4'd1}) begin
        n_fail++;
        $display("FAIL stall%0d: got valid/code/last %b count %0d expected 1000 count 1", s,
                 {bus.op_valid, bus.op_code, bus.op_last}, bus.op_count);
      end
    end
    clear_lanes();
    bus.op_ready = 1'b1;
    for (int n = 1; n < 4; n++) begin
      n_checks++;
      if ({bus.op_valid, bus.op_code, bus.op_last} !== {1'b1, 2'b00, n == 3}) begin
        n_fail++;
        $display("FAIL bp_op%0d: got valid/code/last %b expected %b", n,
                 {bus.op_valid, bus.op_code, bus.op_last}, {1'b1, 2'b00, n == 3});
      end
      tick();
    end
    n_checks++;
    if ({bus.done, bus.op_valid, bus.op_count} !== {2'b10, 4'd4}) begin
      n_fail++; $display("FAIL bp_end: got done/valid=%b count=%0d expected 10 count=4",
                         {bus.done, bus.op_valid}, bus.op_count);
    end
  endtask

  task automatic test_bad_pointer();
    do_clear();
    set_lane(3, 2, 2, 3'b001); tick(); clear_lanes();
    bus.op_ready = 1'b1;
    kick(2, 2);
    n_checks++;
    if ({bus.busy, bus.op_valid, bus.op_code, bus.op_last} !== 5'b11000) begin
      n_fail++; $display("FAIL bad_first: got %b expected 11000", {bus.busy, bus.op_valid, bus.op_code, bus.op_last});
    end
    tick();
    n_checks++;
    if ({bus.op_valid, bus.busy, bus.done, bus.err, bus.op_count} !== {4'b0011, 4'd1}) begin
      n_fail++;
      $display("FAIL bad_stop: got valid/busy/done/err=%b count=%0d expected 0011 count=1",
               {bus.op_valid, bus.busy, bus.done, bus.err}, bus.op_count);
    end
    tick();
    n_checks++;
    if ({bus.done, bus.err} !== 2'b01) begin
      n_fail++; $display("FAIL err_sticky: got done/err %b expected 01", {bus.done, bus.err});
    end
    kick(0, 0);
    n_checks++;
    if ({bus.done, bus.err} !== 2'b10) begin
      n_fail++; $display("FAIL err_cleared: got done/err %b expected 10", {bus.done, bus.err});
    end
    set_lane(0, 2, 2, 3'b101); tick(); clear_lanes();
    kick(2, 2);
    n_checks++;
    if ({bus.op_valid, bus.busy, bus.done, bus.err} !== 4'b0011) begin
      n_fail++; $display("FAIL illegal_code: got valid/busy/done/err %b expected 0011",
                         {bus.op_valid, bus.busy, bus.done, bus.err});
    end
  endtask

  task automatic test_clear();
    set_lane(0, 1, 1, 3'b001);
    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
    clear_lanes();
    set_lane(0, 3, 1, 3'b001); tick(); clear_lanes();
    bus.clear = 1'b1;
    kick(3, 1);
    bus.clear = 1'b0;
    n_checks++;
    if ({bus.busy, bus.op_valid, bus.done} !== 3'b000) begin
      n_fail++; $display("FAIL start_with_clear: got busy/valid/done %b expected 000", {bus.busy, bus.op_valid, bus.done});
    end
    kick(1, 1);
    n_checks++;
    if ({bus.op_valid, bus.done, bus.err} !== 3'b011) begin
      n_fail++; $display("FAIL clear_wins: got valid/done/err %b expected 011", {bus.op_valid, bus.done, bus.err});
    end
  endtask

  task automatic test_collision_reset();
    do_clear();
    set_lane(0, 1, 1, 3'b011);
    set_lane(1, 1, 0, 3'b001);
    set_lane(2, 1, 1, 3'b100);
    set_lane(3, 5, 1, 3'b001);
    tick();
    clear_lanes();
    bus.op_ready = 1'b0;
    kick(1, 1);
    n_checks++;
    if ({bus.op_valid, bus.op_code, bus.op_last} !== 4'b1110) begin
      n_fail++; $display("FAIL collision_op: got valid/code/last %b expected 1110", {bus.op_valid, bus.op_code, bus.op_last});
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_checks++;
    if ({bus.busy, bus.op_valid, bus.op_code, bus.op_last, bus.done, bus.err, bus.op_count} !== 11'b0) begin
      n_fail++;
      $display("FAIL mid_reset: got busy/valid/code/last/done/err %b count %0d expected all 0",
               {bus.busy, bus.op_valid, bus.op_code, bus.op_last, bus.done, bus.err}, bus.op_count);
    end
    bus.op_ready = 1'b1;
    kick(1, 1);
    n_checks++;
    if ({bus.op_valid, bus.done, bus.err} !== 3'b011) begin
      n_fail++; $display("FAIL store_reset: got valid/done/err %b expected 011", {bus.op_valid, bus.done, bus.err});
    end
  endtask

  initial begin
    reset         = 1'b1;
    bus.clear     = 1'b0;
    bus.start     = 1'b0;
    bus.start_row = '0;
    bus.start_col = '0;
    bus.op_ready  = 1'b0;
    clear_lanes();
    test_reset();
    test_diagonal();
    test_mixed();
    test_boundary();
    test_backpressure();
    test_bad_pointer();
    test_clear();
    test_collision_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
